// File: rtl/alarm_pkg.sv
// alarm_pkg: shared definitions for the alarm front-panel logic.
//   - state_t    : button/long-press FSM states.
//   - CLK_FREQ_HZ: board clock, from which default cycle counts are derived.
//   - max_u      : helper used to size shared counters.
package alarm_pkg;

    localparam int unsigned CLK_FREQ_HZ            = 100_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = CLK_FREQ_HZ / 100; // 10 ms
    localparam int unsigned HOLD_CYCLES_DEFAULT     = CLK_FREQ_HZ * 2;   // 2 s
    localparam int unsigned STRETCH_CYCLES_DEFAULT  = 16;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        HOLD,
        FIRE,
        WAIT_RELEASE
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/manual_reset_gen_sync2.sv
// sync2: two-flop synchroniser for a single asynchronous level, with
// asynchronous active-high reset. Reusable for any front-panel button.
//   clk_i : destination clock
//   rst_i : asynchronous reset, active-high (flops clear to 0)
//   d_i   : asynchronous input
//   q_o   : d_i delayed by two clk_i edges
module sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/manual_reset_gen.sv
// manual_reset_gen: turns the raw "clear day" push-button into a clean,
// single-shot, clock-aligned manual_reset request after a debounced long
// press. Reset by the global reset only (never the combined day reset).
//   clk          : system clock
//   reset        : global reset, asynchronous, active-high
//   btn_raw      : raw push-button, asynchronous to clk, active-high
//   manual_reset : registered reset request to the day-reset combiner
//   btn_level    : debounced button level
//   hold_active  : high while a long press is being timed
// Build option: define MANUAL_RESET_STRETCH_EN to hold manual_reset for
// STRETCH_CYCLES cycles; otherwise the pulse is one cycle wide.
module manual_reset_gen
    import alarm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEFAULT,
    parameter int unsigned STRETCH_CYCLES  = STRETCH_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic manual_reset,
    output logic btn_level,
    output logic hold_active
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (HOLD_CYCLES < 2) begin : g_bad_hold
        $error("HOLD_CYCLES must be at least 2");
    end
    if (STRETCH_CYCLES < 1) begin : g_bad_stretch
        $error("STRETCH_CYCLES must be at least 1");
    end

    localparam int unsigned CNT_MAX = max_u(DEBOUNCE_CYCLES, HOLD_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DEB_LAST  = cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam cnt_t HOLD_LAST = cnt_t'(HOLD_CYCLES - 1);

    logic   btn_sync;
    state_t state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   level_q, level_d;
    logic   hold_q, hold_d;
    logic   mr_q, mr_d;

    sync2 u_sync (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (btn_raw),
        .q_o   (btn_sync)
    );

`ifdef MANUAL_RESET_STRETCH_EN
    localparam int unsigned SCNT_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    typedef logic [SCNT_W-1:0] scnt_t;
    localparam scnt_t STRETCH_LAST = scnt_t'(STRETCH_CYCLES - 1);
    scnt_t scnt_q, scnt_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        hold_d  = hold_q;
        mr_d    = mr_q;
`ifdef MANUAL_RESET_STRETCH_EN
        scnt_d  = scnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (btn_sync) begin
                    state_d = DEBOUNCE;
                    cnt_d   = '0;
                end
            end
            DEBOUNCE: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    hold_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    hold_d  = 1'b0;
                end else if (cnt_q == HOLD_LAST) begin
                    // Output goes high on the same edge FIRE is entered.
                    state_d = FIRE;
                    cnt_d   = '0;
                    hold_d  = 1'b0;
                    mr_d    = 1'b1;
`ifdef MANUAL_RESET_STRETCH_EN
                    scnt_d  = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIRE: begin
`ifdef MANUAL_RESET_STRETCH_EN
                // Button state is ignored here; only reset cuts the pulse.
                if (scnt_q == STRETCH_LAST) begin
                    state_d = WAIT_RELEASE;
                    mr_d    = 1'b0;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
`else
                state_d = WAIT_RELEASE;
                mr_d    = 1'b0;
`endif
            end
            WAIT_RELEASE: begin
                if (btn_sync) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
                hold_d  = 1'b0;
                mr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            hold_q  <= 1'b0;
            mr_q    <= 1'b0;
`ifdef MANUAL_RESET_STRETCH_EN
            scnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            hold_q  <= hold_d;
            mr_q    <= mr_d;
`ifdef MANUAL_RESET_STRETCH_EN
            scnt_q  <= scnt_d;
`endif
        end
    end

    assign manual_reset = mr_q;
    assign btn_level    = level_q;
    assign hold_active  = hold_q;

endmodule

// File: tb/tb_manual_reset_gen.sv
module tb_manual_reset_gen;
    import alarm_pkg::*;

`ifdef MANUAL_RESET_STRETCH_EN
    localparam int unsigned EXP_W = 3;
`else
    localparam int unsigned EXP_W = 1;
`endif

    logic clk;
    logic reset;
    logic btn_raw;
    logic manual_reset;
    logic btn_level;
    logic hold_active;

    int checks = 0;
    int errors = 0;

    manual_reset_gen #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (8),
        .STRETCH_CYCLES  (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .manual_reset (manual_reset),
        .btn_level    (btn_level),
        .hold_active  (hold_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Long press from idle: first edge sampling 1 is edge 1, pulse seen after edge 15.
    task automatic test_reset();
        int unsigned first_mr, width, first_lvl;
        reset = 1'b1;
        btn_raw = 1'b1;
        tick(3);
        checks++; if (manual_reset !== 1'b0) begin errors++; $display("FAIL reset_mr got %b want 0", manual_reset); end
        checks++; if (btn_level !== 1'b0) begin errors++; $display("FAIL reset_level got %b want 0", btn_level); end
        checks++; if (hold_active !== 1'b0) begin errors++; $display("FAIL reset_hold got %b want 0", hold_active); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.state_q, IDLE); end
        reset = 1'b0;
        first_mr = 0; width = 0; first_lvl = 0;
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            if (manual_reset === 1'b1) begin
                if (first_mr == 0) first_mr = k;
                width++;
            end
            if (btn_level === 1'b1 && first_lvl == 0) first_lvl = k;
        end
        checks++; if (first_lvl != 7) begin errors++; $display("FAIL reset_level_rise got %0d want 7", first_lvl); end
        checks++; if (first_mr != 15) begin errors++; $display("FAIL reset_first_pulse got %0d want 15", first_mr); end
        checks++; if (width != EXP_W) begin errors++; $display("FAIL reset_pulse_width got %0d want %0d", width, EXP_W); end
        btn_raw = 1'b0;
        tick(10);
    endtask

    task automatic test_glitch();
        int unsigned lvl_seen, mr_seen;
        lvl_seen = 0; mr_seen = 0;
        btn_raw = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 4) btn_raw = 1'b0;
            tick(1);
            if (btn_level === 1'b1) lvl_seen++;
            if (manual_reset === 1'b1) mr_seen++;
        end
        checks++; if (lvl_seen != 0) begin errors++; $display("FAIL glitch_level got %0d cycles want 0", lvl_seen); end
        checks++; if (mr_seen != 0) begin errors++; $display("FAIL glitch_mr got %0d cycles want 0", mr_seen); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL glitch_state got %0d want %0d", dut.state_q, IDLE); end
    endtask

    task automatic test_short_press();
        int unsigned rise, fall, hold_cyc, mr_seen;
        rise = 0; fall = 0; hold_cyc = 0; mr_seen = 0;
        btn_raw = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            if (k == 11) btn_raw = 1'b0;
            tick(1);
            if (btn_level === 1'b1 && rise == 0) rise = k;
            if (btn_level === 1'b0 && rise != 0 && fall == 0) fall = k;
            if (hold_active === 1'b1) hold_cyc++;
            if (manual_reset === 1'b1) mr_seen++;
        end
        checks++; if (rise != 7) begin errors++; $display("FAIL short_level_rise got %0d want 7", rise); end
        checks++; if (fall != 13) begin errors++; $display("FAIL short_level_fall got %0d want 13", fall); end
        checks++; if (hold_cyc != 6) begin errors++; $display("FAIL short_hold_cycles got %0d want 6", hold_cyc); end
        checks++; if (mr_seen != 0) begin errors++; $display("FAIL short_mr got %0d cycles want 0", mr_seen); end
    endtask

    task automatic test_long_hold();
        int unsigned pulses, high_cyc, fall;
        logic prev;
        pulses = 0; high_cyc = 0; fall = 0; prev = 1'b0;
        btn_raw = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            tick(1);
            if (manual_reset === 1'b1) begin
                high_cyc++;
                if (!prev) pulses++;
            end
            prev = manual_reset;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL long_pulses got %0d want 1", pulses); end
        checks++; if (high_cyc != EXP_W) begin errors++; $display("FAIL long_high_cycles got %0d want %0d", high_cyc, EXP_W); end
        checks++; if (hold_active !== 1'b0) begin errors++; $display("FAIL long_hold_in_wait got %b want 0", hold_active); end
        btn_raw = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (btn_level === 1'b0 && fall == 0) fall = k;
        end
        checks++; if (fall != 6) begin errors++; $display("FAIL long_level_fall got %0d want 6", fall); end
    endtask

    task automatic test_release_bounce();
        int unsigned dropped, fall, first_mr;
        dropped = 0; fall = 0; first_mr = 0;
        btn_raw = 1'b1;
        tick(30);
        checks++; if (dut.state_q !== WAIT_RELEASE) begin errors++; $display("FAIL bounce_in_wait got %0d want %0d", dut.state_q, WAIT_RELEASE); end
        for (int k = 0; k < 16; k++) begin
            btn_raw = ((k / 2) % 2 == 1);
            tick(1);
            if (btn_level !== 1'b1) dropped++;
        end
        checks++; if (dropped != 0) begin errors++; $display("FAIL bounce_level_dropped got %0d cycles want 0", dropped); end
        btn_raw = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (btn_level === 1'b0 && fall == 0) fall = k;
        end
        checks++; if (fall != 6) begin errors++; $display("FAIL bounce_level_fall got %0d want 6", fall); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL bounce_state got %0d want %0d", dut.state_q, IDLE); end
        btn_raw = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            if (manual_reset === 1'b1 && first_mr == 0) first_mr = k;
        end
        checks++; if (first_mr != 15) begin errors++; $display("FAIL bounce_refire got %0d want 15", first_mr); end
        btn_raw = 1'b0;
        tick(10);
    endtask

    task automatic test_abort();
        int unsigned mr_seen, first_mr, width;
        mr_seen = 0; first_mr = 0; width = 0;
        btn_raw = 1'b1;
        tick(10);
        checks++; if (hold_active !== 1'b1) begin errors++; $display("FAIL abort_in_hold got %b want 1", hold_active); end
        #1 reset = 1'b1;
        #1;
        checks++; if (btn_level !== 1'b0) begin errors++; $display("FAIL abort_level_async got %b want 0", btn_level); end
        checks++; if (hold_active !== 1'b0) begin errors++; $display("FAIL abort_hold_async got %b want 0", hold_active); end
        btn_raw = 1'b0;
        tick(2);
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (manual_reset === 1'b1) mr_seen++;
        end
        checks++; if (mr_seen != 0) begin errors++; $display("FAIL abort_no_pulse got %0d cycles want 0", mr_seen); end
        btn_raw = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            if (manual_reset === 1'b1) begin
                if (first_mr == 0) first_mr = k;
                width++;
            end
        end
        checks++; if (first_mr != 15) begin errors++; $display("FAIL abort_full_first got %0d want 15", first_mr); end
        checks++; if (width != EXP_W) begin errors++; $display("FAIL abort_full_width got %0d want %0d", width, EXP_W); end
        btn_raw = 1'b0;
        tick(10);
    endtask

    // Reset landing while manual_reset is high must drop it without a clock edge.
    task automatic test_reset_during_fire();
        btn_raw = 1'b1;
        tick(15);
        checks++; if (manual_reset !== 1'b1) begin errors++; $display("FAIL fire_mr_high got %b want 1", manual_reset); end
        #2 reset = 1'b1;
        #1;
        checks++; if (manual_reset !== 1'b0) begin errors++; $display("FAIL fire_mr_async_drop got %b want 0", manual_reset); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL fire_state_async got %0d want %0d", dut.state_q, IDLE); end
        btn_raw = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(4);
    endtask

    initial begin
        reset = 1'b1;
        btn_raw = 1'b0;
        test_reset();
        test_glitch();
        test_short_press();
        test_long_hold();
        test_release_bounce();
        test_abort();
        test_reset_during_fire();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
